// File: rtl/dfe_pkg.sv
// Shared definitions for the DFE output capture block: FSM state encoding,
// default widths and the bit positions of the chain overflow/underflow flags.
package dfe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DFE_DATA_WIDTH = 16;
  localparam int DFE_N_FLAGS    = 10;

  // Bit positions of flags_in / sticky_flags
  localparam int FLAG_IIR_2_4_OVF  = 0;
  localparam int FLAG_IIR_2_4_UDF  = 1;
  localparam int FLAG_IIR_2_OVF    = 2;
  localparam int FLAG_IIR_2_UDF    = 3;
  localparam int FLAG_IIR_1_OVF    = 4;
  localparam int FLAG_IIR_1_UDF    = 5;
  localparam int FLAG_FRAC_DEC_OVF = 6;
  localparam int FLAG_FRAC_DEC_UDF = 7;
  localparam int FLAG_CIC_OVF      = 8;
  localparam int FLAG_CIC_UDF      = 9;

endpackage

// File: rtl/dfe_out_capture_if.sv
// Control, sample-input, buffer-read and status signals of dfe_out_capture.
// The slave modport is the capture block; master is whoever drives and reads it.
interface dfe_out_capture_if
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_DATA_WIDTH,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int N_FLAGS    = DFE_N_FLAGS
);

  logic                          start;
  logic [CNT_WIDTH-1:0]          skip_len;
  logic [CNT_WIDTH-1:0]          capture_len;
  logic                          valid_in;
  logic [DATA_WIDTH-1:0]         data_in;
  logic [N_FLAGS-1:0]            flags_in;
  logic                          m_valid;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_ready;
  logic                          busy;
  logic                          done;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic [CNT_WIDTH-1:0]          stored_cnt;
  logic [CNT_WIDTH-1:0]          drop_cnt;
  logic [N_FLAGS-1:0]            sticky_flags;

  modport master (
    output start, skip_len, capture_len, valid_in, data_in, flags_in, m_ready,
    input  m_valid, m_data, busy, done, level, stored_cnt, drop_cnt, sticky_flags
  );

  modport slave (
    input  start, skip_len, capture_len, valid_in, data_in, flags_in, m_ready,
    output m_valid, m_data, busy, done, level, stored_cnt, drop_cnt, sticky_flags
  );

endinterface

// File: rtl/dfe_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dfe_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_pop;
  logic             w_do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_level   = r_wr - r_rd;
  assign o_data    = r_mem[r_rd[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/dfe_out_capture.sv
// Captures a window of DFE chain output samples into a FWFT buffer after an
// optional settling skip, tracking stored/dropped counts and sticky chain flags.
module dfe_out_capture
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_DATA_WIDTH,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int N_FLAGS    = DFE_N_FLAGS
) (
  input  logic              clk,
  input  logic              rst,
  dfe_out_capture_if.slave  bus
);

  localparam int                   AW      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_skip;
  logic [CNT_WIDTH-1:0] r_cap_len;
  logic [CNT_WIDTH-1:0] r_taken;
  logic [CNT_WIDTH-1:0] r_stored;
  logic [CNT_WIDTH-1:0] r_drop;
  logic [N_FLAGS-1:0]   r_sticky;

  logic                  w_busy;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_sample;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_last;
  logic [AW:0]           w_level;
  logic [DATA_WIDTH-1:0] w_head;

  // A full buffer still has room when the reader frees a slot this cycle
  assign w_pop    = bus.m_ready && !w_empty;
  assign w_room   = !w_full || w_pop;
  assign w_sample = (r_state == ST_CAPTURE) && bus.valid_in;
  assign w_push   = w_sample && w_room;
  assign w_drop   = w_sample && !w_room;
  assign w_last   = w_sample && (r_cap_len != '0) && (r_taken == r_cap_len - CNT_ONE);
  assign w_accept = (r_state == ST_IDLE) && bus.start;

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = (bus.skip_len == '0) ? ST_CAPTURE : ST_SKIP;
      end
      ST_SKIP: begin
        w_busy = 1'b1;
        if (bus.valid_in && (r_skip == CNT_ONE)) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip    <= '0;
      r_cap_len <= '0;
      r_taken   <= '0;
      r_stored  <= '0;
      r_drop    <= '0;
      r_sticky  <= '0;
    end else if (w_accept) begin
      r_skip    <= bus.skip_len;
      r_cap_len <= bus.capture_len;
      r_taken   <= '0;
      r_stored  <= '0;
      r_drop    <= '0;
      r_sticky  <= '0;
    end else begin
      if ((r_state == ST_SKIP) && bus.valid_in) r_skip <= r_skip - CNT_ONE;
      if (w_sample)                     r_taken  <= r_taken + CNT_ONE;
      if (w_push && (r_stored != CNT_MAX)) r_stored <= r_stored + CNT_ONE;
      if (w_drop && (r_drop != CNT_MAX))   r_drop   <= r_drop + CNT_ONE;
      if (w_busy)                       r_sticky <= r_sticky | bus.flags_in;
    end
  end

  dfe_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.data_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level)
  );

  assign bus.m_valid      = !w_empty;
  assign bus.m_data       = w_head;
  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.level        = w_level;
  assign bus.stored_cnt   = r_stored;
  assign bus.drop_cnt     = r_drop;
  assign bus.sticky_flags = r_sticky;

endmodule

// File: tb/tb_dfe_out_capture.sv
// Directed scenarios plus randomized capture runs for dfe_out_capture, checked
// every cycle against a queue-based behavioural model of the capture window.
module tb_dfe_out_capture;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 5;
  localparam int NF    = 10;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk;
  logic rst;

  dfe_out_capture_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .N_FLAGS(NF)) bus ();

  dfe_out_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .N_FLAGS(NF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecked = 0;
  int nFailed  = 0;

  // Reference model: a run is either active (skipping then storing) or not,
  // plus a one-cycle completion marker; the buffer is a plain queue.
  logic [DW-1:0] mQ[$];
  logic [DW-1:0] obsQ[$];
  bit            mRunning = 0;
  bit            mDone    = 0;
  int            mSkipLeft = 0;
  int            mCapLen   = 0;
  int            mTaken    = 0;
  int            mStored   = 0;
  int            mDrop     = 0;
  logic [NF-1:0] mSticky   = '0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecked++;
    assert (obs === exp) else begin
      nFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("busy",    32'(bus.busy),         32'(mRunning));
    checkVal("done",    32'(bus.done),         32'(mDone));
    checkVal("level",   32'(bus.level),        32'(mQ.size()));
    checkVal("m_valid", 32'(bus.m_valid),      32'(mQ.size() != 0));
    checkVal("stored",  32'(bus.stored_cnt),   32'(mStored));
    checkVal("dropped", 32'(bus.drop_cnt),     32'(mDrop));
    checkVal("sticky",  32'(bus.sticky_flags), 32'(mSticky));
    if (mQ.size() != 0) checkVal("m_data", 32'(bus.m_data), 32'(mQ[0]));
  endtask

  task automatic applyStimulus(input bit iRst, input bit iStart, input int iSkip, input int iCap,
                               input bit iValid, input logic [DW-1:0] iData,
                               input logic [NF-1:0] iFlags, input bit iReady);
    bit wasRunning;
    bit wasDone;
    bit popNow;
    rst             = iRst;
    bus.start       = iStart;
    bus.skip_len    = CW'(iSkip);
    bus.capture_len = CW'(iCap);
    bus.valid_in    = iValid;
    bus.data_in     = iData;
    bus.flags_in    = iFlags;
    bus.m_ready     = iReady;
    wasRunning = mRunning;
    wasDone    = mDone;
    popNow     = iReady && (mQ.size() != 0);
    if (!iRst && iReady && (bus.m_valid === 1'b1)) obsQ.push_back(bus.m_data);
    @(posedge clk);
    #1;
    if (iRst) begin
      mQ.delete();
      mRunning = 0; mDone = 0; mSkipLeft = 0; mCapLen = 0; mTaken = 0;
      mStored = 0; mDrop = 0; mSticky = '0;
    end else begin
      mDone = 0;
      if (popNow) void'(mQ.pop_front());
      if (wasRunning) mSticky = mSticky | iFlags;
      if (wasRunning && iValid) begin
        if (mSkipLeft > 0) mSkipLeft--;
        else begin
          if (mQ.size() < DEPTH) begin
            mQ.push_back(iData);
            if (mStored < CMAX) mStored++;
          end else if (mDrop < CMAX) mDrop++;
          mTaken++;
          if (mCapLen != 0 && mTaken == mCapLen) begin
            mRunning = 0;
            mDone    = 1;
          end
        end
      end
      if (iStart && !wasRunning && !wasDone) begin
        mRunning = 1; mSkipLeft = iSkip; mCapLen = iCap; mTaken = 0;
        mStored = 0; mDrop = 0; mSticky = '0;
      end
    end
    checkOutput();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, '0, '0, ready);
  endtask

  task automatic sample(input logic [DW-1:0] d, input logic [NF-1:0] f, input bit ready);
    applyStimulus(0, 0, 0, 0, 1, d, f, ready);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.start = 0; bus.skip_len = '0; bus.capture_len = '0; bus.valid_in = 0;
    bus.data_in = '0; bus.flags_in = '0; bus.m_ready = 0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, '0, '0, 0);
    applyStimulus(1, 1, 0, 0, 1, 16'h1234, '1, 1);
    idle(2, 1);

    $display("[TB] skip 3, capture 5");
    obsQ.delete();
    applyStimulus(0, 1, 3, 5, 0, '0, '0, 1);
    for (int i = 1; i <= 10; i++) begin
      sample(DW'(i), '0, 1);
      if (i == 8) checkVal("s1_done_after_8", 32'(bus.done), 32'd1);
    end
    idle(2, 1);
    checkVal("s1_stored", 32'(bus.stored_cnt), 32'd5);
    checkVal("s1_count", 32'(obsQ.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < obsQ.size()) checkVal("s1_data", 32'(obsQ[i]), 32'(i + 4));

    $display("[TB] overflow with reader stalled");
    obsQ.delete();
    applyStimulus(0, 1, 0, 6, 0, '0, '0, 0);
    for (int i = 1; i <= 6; i++) sample(DW'(16'h10 + i), '0, 0);
    checkVal("s2_level", 32'(bus.level), 32'd4);
    checkVal("s2_drop", 32'(bus.drop_cnt), 32'd2);
    checkVal("s2_done", 32'(bus.done), 32'd1);
    idle(5, 1);
    checkVal("s2_count", 32'(obsQ.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < obsQ.size()) checkVal("s2_data", 32'(obsQ[i]), 32'(16'h11 + i));

    $display("[TB] push and pop on a full buffer");
    obsQ.delete();
    applyStimulus(0, 1, 0, 6, 0, '0, '0, 0);
    for (int i = 1; i <= 4; i++) sample(DW'(16'h20 + i), '0, 0);
    sample(16'h25, '0, 1);
    checkVal("s3_level", 32'(bus.level), 32'd4);
    checkVal("s3_drop", 32'(bus.drop_cnt), 32'd0);
    sample(16'h26, '0, 1);
    checkVal("s3_done", 32'(bus.done), 32'd1);
    idle(6, 1);
    checkVal("s3_count", 32'(obsQ.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < obsQ.size()) checkVal("s3_data", 32'(obsQ[i]), 32'(16'h21 + i));

    $display("[TB] sticky flag during skip");
    applyStimulus(0, 1, 4, 2, 0, '0, '0, 1);
    sample(16'h1, '0, 1);
    sample(16'h2, 10'h008, 1);
    checkVal("s4_sticky_set", 32'(bus.sticky_flags), 32'h008);
    for (int i = 3; i <= 6; i++) sample(DW'(i), '0, 1);
    idle(3, 1);
    checkVal("s4_sticky_hold", 32'(bus.sticky_flags), 32'h008);
    applyStimulus(0, 1, 0, 1, 0, '0, '0, 1);
    checkVal("s4_sticky_clear", 32'(bus.sticky_flags), 32'h000);
    sample(16'h7, '0, 1);
    idle(2, 1);

    $display("[TB] reset mid-run");
    applyStimulus(0, 1, 0, 0, 0, '0, '0, 0);
    for (int i = 1; i <= 3; i++) sample(DW'(16'h30 + i), '0, 0);
    checkVal("s5_level_before", 32'(bus.level), 32'd3);
    applyStimulus(1, 1, 0, 0, 1, 16'h3f, '1, 1);
    checkVal("s5_level", 32'(bus.level), 32'd0);
    checkVal("s5_m_valid", 32'(bus.m_valid), 32'd0);
    checkVal("s5_busy", 32'(bus.busy), 32'd0);
    idle(1, 1);
    checkVal("s5_no_done", 32'(bus.done), 32'd0);

    $display("[TB] unlimited capture, 200 samples");
    obsQ.delete();
    applyStimulus(0, 1, 0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 400; i++)
      applyStimulus(0, 0, 0, 0, (i % 2) == 0, DW'(16'h8000 + i / 2), '0, 1);
    idle(3, 1);
    checkVal("s6_busy", 32'(bus.busy), 32'd1);
    checkVal("s6_drop", 32'(bus.drop_cnt), 32'd0);
    checkVal("s6_stored_sat", 32'(bus.stored_cnt), 32'(CMAX));
    checkVal("s6_count", 32'(obsQ.size()), 32'd200);
    for (int i = 0; i < 200; i++)
      if (i < obsQ.size() && obsQ[i] !== DW'(16'h8000 + i))
        checkVal("s6_order", 32'(obsQ[i]), 32'(16'h8000 + i));
    applyStimulus(1, 0, 0, 0, 0, '0, '0, 0);

    $display("[TB] drop counter saturation");
    applyStimulus(0, 1, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 40; i++) sample(DW'($urandom), '0, 0);
    checkVal("s7_drop_sat", 32'(bus.drop_cnt), 32'(CMAX));
    applyStimulus(1, 0, 0, 0, 0, '0, '0, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      applyStimulus(0, 1, int'($urandom_range(0, 4)), int'($urandom_range(1, 12)),
                    1'($urandom_range(0, 1)), DW'($urandom), '0, 1'($urandom_range(0, 1)));
      guard = 0;
      while ((mRunning || mDone) && guard < 300) begin
        applyStimulus(0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), DW'($urandom),
                      NF'($urandom) & NF'($urandom) & NF'($urandom), 1'($urandom_range(0, 1)));
        guard++;
      end
      checkVal("rand_run_bound", 32'(guard < 300), 32'd1);
    end
    idle(DEPTH + 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nFailed);
    $finish;
  end

endmodule

// File: doc/dfe_out_capture.md
DFE_OUT_CAPTURE -- requirements
Module: dfe_out_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 16: chain output sample width, signed Q1.15.
REQ-002 Parameter FIFO_DEPTH, default 64: capture buffer depth; power of two, at least 4.
REQ-003 Parameter CNT_WIDTH, default 16: width of the length, skip and count fields.
REQ-004 Parameter N_FLAGS, default 10: number of chain overflow/underflow flags monitored.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 start  in  1  one-cycle pulse; arms a capture run.
REQ-008 skip_len  in  CNT_WIDTH  settling samples to discard, sampled on start.
REQ-009 capture_len  in  CNT_WIDTH  samples to store, sampled on start; 0 means unlimited.
REQ-010 valid_in  in  1  sample strobe from chain valid_out.
REQ-011 data_in  in  DATA_WIDTH  chain output sample, qualified by valid_in.
REQ-012 flags_in  in  N_FLAGS  chain iir/frac_dec/cic overflow and underflow flags.
REQ-013 m_valid  out  1  head-of-buffer sample available.
REQ-014 m_data  out  DATA_WIDTH  head-of-buffer sample.
REQ-015 m_ready  in  1  reader accepts m_data.
REQ-016 busy  out  1  high in SKIP or CAPTURE.
REQ-017 done  out  1  one-cycle pulse when the run completes.
REQ-018 level  out  log2(FIFO_DEPTH)+1  buffer occupancy.
REQ-019 stored_cnt  out  CNT_WIDTH  samples written this run.
REQ-020 drop_cnt  out  CNT_WIDTH  samples lost to a full buffer this run.
REQ-021 sticky_flags  out  N_FLAGS  OR of flags_in seen while busy.

Function
REQ-022 FSM states: IDLE, SKIP, CAPTURE, DONE.
REQ-023 IDLE, start: latch skip_len and capture_len; clear stored_cnt, drop_cnt and sticky_flags; go to SKIP, or to CAPTURE when skip_len = 0.
REQ-024 SKIP: each valid_in decrements the skip counter and discards the sample; when the counter reaches 1 on a valid_in, go to CAPTURE.
REQ-025 CAPTURE: each valid_in is stored if the buffer has room, else it is dropped; either outcome counts toward capture_len.
REQ-026 CAPTURE exit: on the valid_in that makes stored + dropped = capture_len (capture_len != 0), go to DONE.
REQ-027 DONE: assert done for exactly 1 cycle; next state is IDLE. The buffer is retained until it is read.
REQ-028 start while busy or in DONE: ignored.
REQ-029 Buffer read: first-word-fall-through. m_valid = !empty and m_data = head. Pop when m_valid && m_ready.
REQ-030 Latency: a sample written at edge t is visible on m_valid/m_data after edge t, i.e. m_valid rises in the cycle following the write.
REQ-031 Buffer full with a push and a pop in the same cycle: both proceed, no drop, level unchanged.
REQ-032 Buffer full with a push and no pop: sample dropped; drop_cnt increments; level holds at FIFO_DEPTH.
REQ-033 Buffer empty: m_ready has no effect; level does not underflow.
REQ-034 Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from an extra wrap bit.
REQ-035 stored_cnt and drop_cnt saturate at all-ones with no wrap.
REQ-036 sticky_flags[k] sets on flags_in[k] while busy and holds until the next accepted start or reset.
REQ-037 m_data is a bit-exact copy of data_in, with no sign or width change.
REQ-038 valid_in while in IDLE or DONE: ignored.

Reset
REQ-039 On rst high at a clock edge: state is IDLE; pointers, level, stored_cnt, drop_cnt and sticky_flags are 0; m_valid, busy and done are 0.
REQ-040 rst asserted mid-run: aborts the run and empties the buffer; no done pulse is produced.
REQ-041 rst has priority over start, valid_in and m_ready in the same cycle.

Structure
REQ-042 A shared package dfe_pkg holds the FSM state enum, DATA_WIDTH/N_FLAGS defaults, and the flag bit-index constants (iir_2_4, iir_2, iir_1, frac_dec, cic overflow/underflow).
REQ-043 One sub-module, dfe_sync_fifo (FIFO_DEPTH x DATA_WIDTH, FWFT, with level), is instantiated once; the FSM and counters live in dfe_out_capture.

Verification
REQ-044 Scenario: start with skip_len=3, capture_len=5; 10 valid_in with data 1..10 and m_ready=1 -> m_data sequence 4,5,6,7,8; done one cycle after the valid_in carrying 8; stored_cnt=5.
REQ-045 Scenario: FIFO_DEPTH=4, m_ready=0, capture_len=6 -> level=4, drop_cnt=2, done asserted; draining then gives the first 4 samples.
REQ-046 Scenario: buffer full, valid_in and m_ready in the same cycle -> no drop, level stays 4, order preserved.
REQ-047 Scenario: flags_in[3] pulsed once during SKIP -> sticky_flags=0x008 until the next start, which clears it to 0.
REQ-048 Scenario: rst pulsed with 3 samples buffered -> next cycle level=0, m_valid=0, state IDLE, no done.
REQ-049 Scenario: capture_len=0 with valid_in every 2nd cycle for 200 samples and m_ready=1 -> busy stays 1, 200 samples out in order, drop_cnt=0.
